mac_seq: RTL and testbench

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_seq.sv | 95 +++++++++
 tb/tb_mac_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// Sequenced dot-product feeder: holds two operand banks, streams A[i]/B[i] pairs
// to an external accumulator and captures the accumulator's final output.
module mac_seq #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 start,
  input  logic [AW:0]          len,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] result,
  output logic                 err,
  output logic                 mac_new,
  output logic signed [DW-1:0] mac_a,
  output logic signed [DW-1:0] mac_b,
  input  logic signed [DW-1:0] mac_p
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t              state;
  logic [AW-1:0]       idx;
  logic [AW:0]         len_q;
  logic signed [DW-1:0] bank_a [DEPTH];
  logic signed [DW-1:0] bank_b [DEPTH];
  logic                len_ok;
  logic                last_pair;

  assign busy      = (state == FEED) || (state == DRAIN);
  assign len_ok    = (len >= (AW+1)'(1)) && (len <= (AW+1)'(DEPTH));
  assign last_pair = ({1'b0, idx} == (len_q - (AW+1)'(1)));

  // Operands are driven straight from the banks; banks cannot change while busy.
  assign mac_a   = (state == FEED) ? bank_a[idx] : '0;
  assign mac_b   = (state == FEED) ? bank_b[idx] : '0;
  assign mac_new = (state == FEED) && (idx == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      len_q  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (wr_en && !busy) begin
        if (wr_sel) bank_b[wr_addr] <= wr_data;
        else        bank_a[wr_addr] <= wr_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q <= len;
              idx   <= '0;
              state <= FEED;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FEED: begin
          idx <= idx + AW'(1);
          if (last_pair) state <= DRAIN;
        end
        DRAIN: begin
          result <= mac_p;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Randomized self-checking bench for mac_seq with an external accumulator model
// and a dot-product reference computed from the operand-bank contents.
module tb_mac_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_en;
  logic               wr_sel;
  logic [3:0]         wr_addr;
  logic signed [31:0] wr_data;
  logic               start;
  logic [4:0]         len;
  logic               busy;
  logic               done;
  logic signed [31:0] result;
  logic               err;
  logic               mac_new;
  logic signed [31:0] mac_a;
  logic signed [31:0] mac_b;
  logic signed [31:0] mac_p;

  int checks = 0;
  int errors = 0;
  int ma [16];
  int mb [16];
  int exp_res = 0;

  mac_seq #(.DW(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .len(len),
    .busy(busy), .done(done), .result(result), .err(err),
    .mac_new(mac_new), .mac_a(mac_a), .mac_b(mac_b), .mac_p(mac_p)
  );

  always #5 clk = ~clk;

  // External accumulator: load on mac_new, otherwise add the product each cycle.
  logic signed [63:0] acc = '0;
  always @(posedge clk) begin
    if (mac_new) acc <= longint'(mac_a) * longint'(mac_b);
    else         acc <= acc + longint'(mac_a) * longint'(mac_b);
  end
  assign mac_p = acc[55:24];

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_dot(input int n);
    logic signed [63:0] s = '0;
    for (int i = 0; i < n; i++) s += longint'(ma[i]) * longint'(mb[i]);
    return int'(s[55:24]);
  endfunction

  task automatic wr(input bit sel, input int addr, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
    if (sel) mb[addr] = data; else ma[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic err_try(input int l);
    start = 1'b1; len = 5'(l);
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    @(negedge clk);
    check("err_clear", err, 0);
    check("err_result", result, exp_res);
  endtask

  // mode 0 plain, 1 write+start mid-run, 2 start in DONE,
  // 3 write A[0] on the start edge, 4 reset in FEED cycle 2
  task automatic run(input int l, input int mode);
    int exp;
    start = 1'b1; len = 5'(l);
    if (mode == 3) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = $urandom;
      ma[0] = wr_data;
    end
    exp = ref_dot(l);
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= l + 2; c++) begin
      check("busy", busy, (c <= l + 1));
      check("mac_new", mac_new, (c == 1));
      check("done", done, (c == l + 2));
      if (c <= l) begin
        check("mac_a", mac_a, ma[c-1]);
        check("mac_b", mac_b, mb[c-1]);
      end else begin
        check("mac_a_idle", mac_a, 0);
        check("mac_b_idle", mac_b, 0);
      end
      if (c == l + 2) begin
        check("result", result, exp);
        exp_res = exp;
      end
      if (mode == 4 && c == 2) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_mac_new", mac_new, 0);
        check("rst_mac_a", mac_a, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin ma[i] = 0; mb[i] = 0; end
        exp_res = 0;
        for (int k = 0; k < l + 2; k++) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        return;
      end
      if (mode == 1 && c == 2) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b1;
      end
      if (mode == 2 && c == l + 2) start = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      if (mode != 2) start = 1'b0;
    end
    if (mode == 2) begin
      check("done_start_ignored", busy, 0);
      start = 1'b0;
      @(negedge clk);
      check("done_start_idle", busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0;
    for (int i = 0; i < 16; i++) begin ma[i] = 0; mb[i] = 0; end
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_result", result, 0);
    check("reset_mac_new", mac_new, 0);
    check("reset_mac_a", mac_a, 0);
    check("reset_mac_b", mac_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    wr(0, 0, 4096); wr(0, 1, 8192); wr(0, 2, -4096);
    wr(1, 0, 4096); wr(1, 1, 4096); wr(1, 2, 4096);
    run(3, 0);
    check("dot3_is_2", exp_res, 2);

    run(1, 0);
    check("dot1_is_1", exp_res, 1);
    for (int i = 0; i < 16; i++) begin wr(0, i, 4096); wr(1, i, 4096); end
    run(16, 0);
    check("dot16_is_16", exp_res, 16);

    err_try(0);
    err_try(17);

    run(4, 1);
    run(4, 0);
    run(3, 3);
    run(2, 2);

    for (int it = 0; it < 30; it++) begin
      int nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++)
        wr(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
      if ($urandom_range(0, 7) == 0)
        err_try($urandom_range(0, 1) ? 0 : $urandom_range(17, 31));
      else
        run($urandom_range(1, 16), 0);
    end

    for (int i = 0; i < 8; i++) begin wr(0, i, $urandom); wr(1, i, $urandom); end
    run(8, 4);
    run(1, 0);
    check("post_reset_zero", result, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
